// File: rtl/vgacon_pkg.sv
// rtl/vgacon_pkg.sv - shared constants, state encoding and helpers for the VGA text console writer
package vgacon_pkg;

    localparam int NUM_ROWS_DEF = 3;
    localparam int NUM_COLS_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_SCROLL,
        ST_CLR_ROW,
        ST_CLR_ALL
    } state_e;

    typedef enum logic [2:0] {
        CUR_HOLD,
        CUR_ADV,
        CUR_CR,
        CUR_LF,
        CUR_BS,
        CUR_HOME
    } cur_op_e;

    localparam logic [6:0] CH_BS = 7'h08;
    localparam logic [6:0] CH_LF = 7'h0A;
    localparam logic [6:0] CH_FF = 7'h0C;
    localparam logic [6:0] CH_CR = 7'h0D;

    localparam logic [8:0] BLANK_CELL = 9'h020;

    // Ten columns is the only width in use; shift-add keeps the multiplier out.
    function automatic int row_base(input logic [1:0] row, input int ncols);
        if (ncols == 10)
            return (int'(row) << 3) + (int'(row) << 1);
        else
            return int'(row) * ncols;
    endfunction

endpackage

// File: rtl/vgacon_cursor.sv
// rtl/vgacon_cursor.sv - cursor row/column registers with advance, wrap, CR, LF, BS and home
module vgacon_cursor
    import vgacon_pkg::*;
#(
    parameter int NUM_ROWS = NUM_ROWS_DEF,
    parameter int NUM_COLS = NUM_COLS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  cur_op_e    op_i,
    output logic [1:0] row_o,
    output logic [3:0] col_o,
    output logic       at_last_row_o,
    output logic       at_last_cell_o
);

    localparam logic [1:0] LAST_ROW = 2'(NUM_ROWS - 1);
    localparam logic [3:0] LAST_COL = 4'(NUM_COLS - 1);

    logic [1:0] row_q, row_d;
    logic [3:0] col_q, col_d;

    // The row never advances past the last row; scrolling makes room instead.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        case (op_i)
            CUR_ADV: begin
                if (col_q == LAST_COL) begin
                    col_d = 4'd0;
                    if (row_q != LAST_ROW) row_d = row_q + 2'd1;
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
            CUR_CR: col_d = 4'd0;
            CUR_LF: begin
                col_d = 4'd0;
                if (row_q != LAST_ROW) row_d = row_q + 2'd1;
            end
            CUR_BS: if (col_q != 4'd0) col_d = col_q - 4'd1;
            CUR_HOME: begin
                row_d = 2'd0;
                col_d = 4'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= 2'd0;
            col_q <= 4'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o          = row_q;
    assign col_o          = col_q;
    assign at_last_row_o  = (row_q == LAST_ROW);
    assign at_last_cell_o = (row_q == LAST_ROW) && (col_q == LAST_COL);

endmodule

// File: rtl/vgacon_tty_ctrl.sv
// rtl/vgacon_tty_ctrl.sv - terminal-style write controller and scroller for the console text buffer
module vgacon_tty_ctrl
    import vgacon_pkg::*;
#(
    parameter int NUM_ROWS = NUM_ROWS_DEF,
    parameter int NUM_COLS = NUM_COLS_DEF,
    parameter int ADDR_W   = 5,
    parameter int CELL_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_char,
    input  logic [1:0]        in_color,
    input  logic              clear_req,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [CELL_W-1:0] buf_wdata,
    output logic [ADDR_W-1:0] buf_raddr,
    input  logic [CELL_W-1:0] buf_rdata,
    output logic [1:0]        cursor_row,
    output logic [3:0]        cursor_col,
    output logic              busy,
    output logic              scroll_done
);

    localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] NCOLS_A    = ADDR_W'(NUM_COLS);
    localparam logic [ADDR_W-1:0] COPY_LAST  = ADDR_W'((NUM_ROWS - 1) * NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] LROW_BASE  = ADDR_W'((NUM_ROWS - 1) * NUM_COLS);
    localparam logic [ADDR_W-1:0] CELL_LAST  = ADDR_W'(NUM_ROWS * NUM_COLS - 1);
    localparam logic [CELL_W-1:0] BLANK      = CELL_W'(BLANK_CELL);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [CELL_W-1:0]   cell_q, cell_d;
    logic                wrap_q, wrap_d;
    logic                clear_pend_q, clear_pend_d;
    logic                scroll_done_q, scroll_done_d;
    cur_op_e             cur_op;
    logic                at_last_row, at_last_cell;
    logic [ADDR_W-1:0]   cur_addr;
    logic                accept;

    vgacon_cursor #(
        .NUM_ROWS(NUM_ROWS),
        .NUM_COLS(NUM_COLS)
    ) u_cursor (
        .clk           (clk),
        .rst           (rst),
        .op_i          (cur_op),
        .row_o         (cursor_row),
        .col_o         (cursor_col),
        .at_last_row_o (at_last_row),
        .at_last_cell_o(at_last_cell)
    );

    assign cur_addr = ADDR_W'(row_base(cursor_row, NUM_COLS) + int'(cursor_col));
    assign in_ready = (state_q == ST_IDLE) && !clear_req && !clear_pend_q && !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE);
    assign scroll_done = scroll_done_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        waddr_d       = waddr_q;
        cell_d        = cell_q;
        wrap_d        = wrap_q;
        clear_pend_d  = clear_pend_q;
        scroll_done_d = 1'b0;
        cur_op        = CUR_HOLD;
        buf_we        = 1'b0;
        buf_waddr     = '0;
        buf_wdata     = '0;
        buf_raddr     = '0;

        // Clears arriving while busy collapse into a single deferred clear.
        if (state_q != ST_IDLE && clear_req) clear_pend_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (clear_req || clear_pend_q) begin
                    state_d      = ST_CLR_ALL;
                    idx_d        = '0;
                    clear_pend_d = 1'b0;
                    cur_op       = CUR_HOME;
                end else if (accept) begin
                    if (in_char >= 7'h20 && in_char <= 7'h7E) begin
                        waddr_d = cur_addr;
                        cell_d  = CELL_W'({in_color, in_char});
                        wrap_d  = at_last_cell;
                        cur_op  = CUR_ADV;
                        state_d = ST_WR;
                    end else begin
                        case (in_char)
                            CH_CR: cur_op = CUR_CR;
                            CH_LF: begin
                                cur_op = CUR_LF;
                                if (at_last_row) begin
                                    state_d = ST_SCROLL;
                                    idx_d   = '0;
                                end
                            end
                            CH_BS: begin
                                if (cursor_col != 4'd0) begin
                                    cur_op  = CUR_BS;
                                    waddr_d = cur_addr - ONE_A;
                                    cell_d  = BLANK;
                                    wrap_d  = 1'b0;
                                    state_d = ST_WR;
                                end
                            end
                            CH_FF: begin
                                state_d = ST_CLR_ALL;
                                idx_d   = '0;
                                cur_op  = CUR_HOME;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_WR: begin
                buf_we    = 1'b1;
                buf_waddr = waddr_q;
                buf_wdata = cell_q;
                idx_d     = '0;
                state_d   = wrap_q ? ST_SCROLL : ST_IDLE;
            end
            ST_SCROLL: begin
                buf_we    = 1'b1;
                buf_raddr = idx_q + NCOLS_A;
                buf_waddr = idx_q;
                buf_wdata = buf_rdata;
                // idx carries straight on into the last-row clear.
                if (idx_q == COPY_LAST) begin
                    idx_d   = LROW_BASE;
                    state_d = ST_CLR_ROW;
                end else begin
                    idx_d = idx_q + ONE_A;
                end
            end
            ST_CLR_ROW, ST_CLR_ALL: begin
                buf_we    = 1'b1;
                buf_waddr = idx_q;
                buf_wdata = BLANK;
                if (idx_q == CELL_LAST) begin
                    idx_d         = '0;
                    state_d       = ST_IDLE;
                    scroll_done_d = (state_q == ST_CLR_ROW);
                end else begin
                    idx_d = idx_q + ONE_A;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            waddr_q       <= '0;
            cell_q        <= '0;
            wrap_q        <= 1'b0;
            clear_pend_q  <= 1'b0;
            scroll_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            waddr_q       <= waddr_d;
            cell_q        <= cell_d;
            wrap_q        <= wrap_d;
            clear_pend_q  <= clear_pend_d;
            scroll_done_q <= scroll_done_d;
        end
    end

endmodule

// File: tb/tb_vgacon_tty_ctrl.sv
// tb/tb_vgacon_tty_ctrl.sv - self-checking bench for vgacon_tty_ctrl against a screen-level model
module tb_vgacon_tty_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_char;
    logic [1:0] in_color;
    logic       clear_req;
    logic       buf_we;
    logic [4:0] buf_waddr;
    logic [8:0] buf_wdata;
    logic [4:0] buf_raddr;
    logic [8:0] buf_rdata;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;
    logic       scroll_done;

    logic [8:0] mem      [0:31];
    logic [8:0] fill_val [0:31];
    logic       fill_en;

    logic [8:0] em [0:29];
    int         er, ec;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    vgacon_tty_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .in_color   (in_color),
        .clear_req  (clear_req),
        .buf_we     (buf_we),
        .buf_waddr  (buf_waddr),
        .buf_wdata  (buf_wdata),
        .buf_raddr  (buf_raddr),
        .buf_rdata  (buf_rdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy),
        .scroll_done(scroll_done)
    );

    assign buf_rdata = mem[buf_raddr];

    always @(posedge clk) begin
        if (fill_en) begin
            for (int k = 0; k < 32; k++) mem[k] <= fill_val[k];
        end else if (buf_we) begin
            mem[buf_waddr] <= buf_wdata;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mism();
        int n = 0;
        for (int k = 0; k < 30; k++) if (mem[k] !== em[k]) n++;
        return n;
    endfunction

    task automatic model_scroll();
        for (int k = 0; k < 20; k++) em[k] = em[k + 10];
        for (int k = 20; k < 30; k++) em[k] = 9'h020;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 30; k++) em[k] = 9'h020;
        er = 0;
        ec = 0;
    endtask

    task automatic model_char(input logic [6:0] ch, input logic [1:0] co,
                              output int nb, output int nw, output int ns);
        nb = 0; nw = 0; ns = 0;
        if (ch >= 7'h20 && ch <= 7'h7E) begin
            em[er * 10 + ec] = {co, ch};
            nb = 1; nw = 1;
            if (ec == 9) begin
                ec = 0;
                if (er == 2) begin
                    model_scroll();
                    nb = 31; nw = 31; ns = 1;
                end else begin
                    er++;
                end
            end else begin
                ec++;
            end
        end else if (ch == 7'h0D) begin
            ec = 0;
        end else if (ch == 7'h0A) begin
            ec = 0;
            if (er < 2) er++;
            else begin
                model_scroll();
                nb = 30; nw = 30; ns = 1;
            end
        end else if (ch == 7'h08) begin
            if (ec > 0) begin
                ec--;
                em[er * 10 + ec] = 9'h020;
                nb = 1; nw = 1;
            end
        end else if (ch == 7'h0C) begin
            model_clear();
            nb = 30; nw = 30;
        end
    endtask

    task automatic send(input logic [6:0] ch, input logic [1:0] co);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_char  = ch;
        in_color = co;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic measure(output int nb, output int nw, output int ns, output logic rdy);
        bit done = 0;
        nb = 0; nw = 0; ns = 0; rdy = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (buf_we) nw++;
            if (scroll_done) ns++;
            if (busy) nb++;
            else begin
                done = 1;
                rdy  = in_ready;
            end
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_row"}, int'(cursor_row), er);
        chk({tag, "_col"}, int'(cursor_col), ec);
        chk({tag, "_buffer_mism"}, mism(), 0);
    endtask

    task automatic step(input logic [6:0] ch, input logic [1:0] co);
        int enb, enw, ens, nb, nw, ns;
        logic rdy;
        model_char(ch, co, enb, enw, ens);
        send(ch, co);
        measure(nb, nw, ns, rdy);
        chk("busy_cycles", nb, enb);
        chk("writes", nw, enw);
        chk("scroll_done", ns, ens);
        chk("ready_after", int'(rdy), 1);
        check_state("step");
    endtask

    function automatic logic [6:0] rand_printable();
        return 7'($urandom_range(32, 126));
    endfunction

    function automatic logic [6:0] rand_code();
        int r = $urandom_range(0, 15);
        int t;
        if (r <= 9) return rand_printable();
        case (r)
            10: return 7'h0D;
            11, 14: return 7'h0A;
            12: return 7'h08;
            15: return 7'h0C;
            default: begin
                t = $urandom_range(0, 31);
                if (t == 8 || t == 10 || t == 12 || t == 13) t = 127;
                return 7'(t);
            end
        endcase
    endfunction

    initial begin
        int nb, nw, ns;
        logic rdy;

        for (int k = 0; k < 32; k++) fill_val[k] = {2'($urandom_range(0, 3)), rand_printable()};
        for (int k = 0; k < 30; k++) em[k] = fill_val[k];
        er = 0; ec = 0;
        rst = 1'b1; fill_en = 1'b1; in_valid = 1'b0; in_char = 7'h00; in_color = 2'd0; clear_req = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_buf_we", int'(buf_we), 0);
        chk("rst_buf_waddr", int'(buf_waddr), 0);
        chk("rst_buf_wdata", int'(buf_wdata), 0);
        chk("rst_buf_raddr", int'(buf_raddr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_scroll_done", int'(scroll_done), 0);
        chk("rst_row", int'(cursor_row), 0);
        chk("rst_col", int'(cursor_col), 0);
        rst = 1'b0; fill_en = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", int'(in_ready), 1);

        step(7'h41, 2'd2);
        chk("A_cell", int'(mem[0]), 9'h141);
        for (int i = 0; i < 9; i++) step(rand_printable(), 2'($urandom_range(0, 3)));
        chk("row0_last_cell", int'(mem[9] === em[9]), 1);
        for (int i = 0; i < 3; i++) step(rand_printable(), 2'($urandom_range(0, 3)));
        step(7'h08, 2'd0);
        chk("bs_cell12", int'(mem[12]), 9'h020);
        step(7'h0D, 2'd0);
        step(7'h0A, 2'd0);
        step(7'h0C, 2'd0);
        step(7'h08, 2'd0);

        for (int i = 0; i < 30; i++) step(rand_printable(), 2'($urandom_range(0, 3)));
        chk("wrap_scroll_row", int'(cursor_row), 2);

        for (int i = 0; i < 80; i++) step(rand_code(), 2'($urandom_range(0, 3)));

        // two clear pulses during an LF scroll collapse into one clear
        while (er < 2) step(7'h0A, 2'd0);
        model_char(7'h0A, 2'd0, nb, nw, ns);
        send(7'h0A, 2'd0);
        fork
            begin
                repeat (3) @(negedge clk);
                clear_req = 1'b1;
                @(negedge clk);
                clear_req = 1'b0;
                repeat (6) @(negedge clk);
                clear_req = 1'b1;
                @(negedge clk);
                clear_req = 1'b0;
            end
        join_none
        measure(nb, nw, ns, rdy);
        chk("pend_scroll_busy", nb, 30);
        chk("pend_scroll_done", ns, 1);
        chk("pend_ready_blocked", int'(rdy), 0);
        measure(nb, nw, ns, rdy);
        model_clear();
        chk("pend_clear_busy", nb, 30);
        chk("pend_clear_writes", nw, 30);
        chk("pend_clear_no_sd", ns, 0);
        chk("pend_clear_ready", int'(rdy), 1);
        check_state("pend_clear");

        // clear_req coincident with a character in IDLE
        for (int i = 0; i < 5; i++) step(rand_printable(), 2'($urandom_range(0, 3)));
        @(negedge clk);
        in_valid = 1'b1; in_char = 7'h5A; in_color = 2'd1; clear_req = 1'b1;
        #1 chk("ready_with_clear", int'(in_ready), 0);
        @(posedge clk);
        #1 begin in_valid = 1'b0; clear_req = 1'b0; end
        measure(nb, nw, ns, rdy);
        model_clear();
        chk("coinc_clear_busy", nb, 30);
        chk("coinc_clear_writes", nw, 30);
        check_state("coinc_clear");

        // reset during copy cycle 7 of a scroll
        for (int i = 0; i < 4; i++) step(rand_printable(), 2'($urandom_range(0, 3)));
        while (er < 2) step(7'h0A, 2'd0);
        send(7'h0A, 2'd0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 8; k++) em[k] = em[k + 10];
        er = 0; ec = 0;
        chk("abort_buf_we", int'(buf_we), 0);
        chk("abort_busy", int'(busy), 0);
        rst = 1'b0;
        check_state("abort");
        for (int i = 0; i < 3; i++) step(7'h0A, 2'd0);
        for (int i = 0; i < 20; i++) step(rand_code(), 2'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vgacon_tty_ctrl.md
# vgacon_tty_ctrl

Terminal-style write controller for the 3×10 VGA text console buffer. It accepts a stream of 7-bit characters with a 2-bit colour index and keeps a hardware cursor. It interprets CR, LF, BS and FF, wraps at the end of a line, and scrolls the buffer up by one row by sequencing cell copies through the buffer's write port. It sits between the TinyQV register interface and the console text buffer, and is the only writer of that buffer.

## Interface
Parameters:
- `NUM_ROWS`, 3: text rows.
- `NUM_COLS`, 10: text columns.
- `ADDR_W`, 5: buffer address width (≥ clog2(NUM_ROWS·NUM_COLS)).
- `CELL_W`, 9: cell width, {colour[1:0], char[6:0]}.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `in_valid`  in  1: a character is offered.
- `in_ready`  out  1: the controller accepts when `in_valid && in_ready` at a rising edge.
- `in_char`  in  7: character code.
- `in_color`  in  2: colour index stored with printable characters.
- `clear_req`  in  1: one-cycle pulse requesting a full-screen clear.
- `buf_we`  out  1: buffer write strobe.
- `buf_waddr`  out  ADDR_W: buffer write address.
- `buf_wdata`  out  CELL_W: buffer write data.
- `buf_raddr`  out  ADDR_W: buffer read address. The buffer read is combinational.
- `buf_rdata`  in  CELL_W: buffer cell at `buf_raddr`, valid in the same cycle.
- `cursor_row`  out  2: current row.
- `cursor_col`  out  4: current column.
- `busy`  out  1: high in any state other than IDLE.
- `scroll_done`  out  1: one-cycle pulse when a scroll completes. Used as an interrupt source.

## Operation
States:
- IDLE: waits for input.
- WR: single-cycle cell write.
- SCROLL: copies rows up, using counter `idx`.
- CLR_ROW: clears the last row.
- CLR_ALL: clears the whole buffer.

Readiness:
- `in_ready` = (state==IDLE) && !clear_req && !clear_pend.

Character handling on acceptance in IDLE:
- 0x20–0x7E:
  - Latch cell {in_color, in_char} and address row·NUM_COLS+col, then go to WR.
  - The cursor then advances. If col==NUM_COLS-1, col←0 and row←row+1.
  - If the cursor was at the last cell (row==NUM_ROWS-1, col==NUM_COLS-1), row stays and WR→SCROLL. Otherwise WR→IDLE.
- 0x0D (CR): col←0. Stays in IDLE.
- 0x0A (LF): col←0. If row<NUM_ROWS-1, row←row+1 and stay in IDLE. Otherwise go to SCROLL with row unchanged.
- 0x08 (BS): if col>0, col←col-1 and go to WR writing cell 0x020 at the new position. At col 0 it is a no-op.
- 0x0C (FF): go to CLR_ALL. Cursor←(0,0).
- Any other code: consumed and ignored.

SCROLL:
- `idx` runs 0..(NUM_ROWS-1)·NUM_COLS-1. Each cycle: `buf_raddr`=idx+NUM_COLS, `buf_waddr`=idx, `buf_wdata`=`buf_rdata` (combinational), `buf_we`=1.
- After the last idx, go to CLR_ROW.

CLR_ROW:
- Writes 0x020 to addresses (NUM_ROWS-1)·NUM_COLS .. NUM_ROWS·NUM_COLS-1, one per cycle.
- Then `scroll_done` pulses and the state goes to IDLE.

CLR_ALL:
- Writes 0x020 to addresses 0..NUM_ROWS·NUM_COLS-1, then goes to IDLE.
- Does not pulse `scroll_done`.

clear_req:
- In IDLE: go to CLR_ALL and set cursor←(0,0). No character is accepted that cycle.
- In any other state: set `clear_pend`. On return to IDLE, go directly to CLR_ALL and clear `clear_pend`.
- Multiple pulses while busy collapse into one clear.

Arithmetic:
- row·NUM_COLS is computed as (row<<3)+(row<<1) for the default parameters.
- `idx` is ADDR_W wide and never exceeds NUM_ROWS·NUM_COLS-1.

## Timing
- Reset values:
  - state=IDLE, cursor=(0,0), `clear_pend`=0, `idx`=0.
  - `buf_we`=0, `buf_waddr`=0, `buf_wdata`=0, `buf_raddr`=0.
  - `busy`=0, `scroll_done`=0.
  - `in_ready` is forced to 0 while `rst` is high.
- Reset mid-operation aborts immediately. The buffer is left partially written and is not cleared by reset.
- Printable or BS character accepted at edge N: `buf_we` is high for the single cycle between edges N and N+1 (state WR). `in_ready` is low in that cycle. Throughput is 1 character per 2 cycles.
- Scroll: exactly 20 copy cycles plus 10 clear cycles (defaults), with `busy` high for all 30.
  - For an LF trigger these 30 cycles directly follow acceptance.
  - For a wrapping printable character they follow the WR cycle.
  - `scroll_done` is high in the cycle after the last clear write. IDLE and `in_ready` resume in that same cycle.
- Clear: 30 write cycles, then IDLE.
- `buf_we` is 0 in IDLE. CR/LF-without-scroll, ignored codes and BS at col 0 produce no write.

## Structure
- A shared package `vgacon_pkg` holds:
  - the NUM_ROWS/NUM_COLS defaults;
  - the state encoding;
  - the control codes CR/LF/BS/FF;
  - the blank cell constant 9'h020.
- One natural sub-module, `vgacon_cursor`: row/col registers with advance, wrap, CR, BS and home operations, plus a `at_last_cell` flag.

## Test plan
- Reset, then write "A" (0x41, colour 2): one write, addr 0, data 0x141. Cursor becomes (0,1). `in_ready` is low for exactly 1 cycle.
- 10 printables on row 0: the 10th writes addr 9. Cursor becomes (1,0). No scroll.
- Fill to (2,9), then write one more char: write to addr 29, then 30 `busy` cycles. Addr k receives old cell k+10 for k<20. Addrs 20–29 receive 0x020. `scroll_done` pulses once. Cursor ends at (2,0).
- BS at (1,3): write 0x020 to addr 12, cursor becomes (1,2). BS at (0,0): no write, cursor unchanged.
- `clear_req` pulsed twice during a scroll: after `scroll_done`, exactly one 30-cycle clear follows with cursor (0,0). A `clear_req` coincident with `in_valid` in IDLE: the character is not accepted.
- Assert `rst` at copy cycle 7 of a scroll: the next cycle shows `buf_we`=0, cursor (0,0), `busy`=0. The post-reset LF stream behaves normally.
